// File: rtl/ud_counter_pkg.sv
// Shared defaults and direction encoding for the up/down counter core.
package ud_counter_pkg;

  localparam int unsigned WIDTH_DEF           = 8;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/ud_counter_core_sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous input, with a prev flop for
// rising-edge detection on the synchronized level.
module sync_edge_det
  import ud_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/ud_counter_core.sv
// Up/down counter clocked by clk only; the muxed slow clock is sampled as data.
// Optional pause-button debouncer enabled by defining UD_COUNTER_DEBOUNCE_EN.
module ud_counter_core
  import ud_counter_pkg::*;
#(
  parameter int unsigned WIDTH           = WIDTH_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk_in,
  input  logic             dir,
  input  logic             pause_btn,
  input  logic             inv,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             paused,
  output logic             tick
);

  localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
    $error("ud_counter_core: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic             w_slow_lvl;
  logic             w_slow_rise;
  logic             w_pause_lvl;
  logic             w_pause_sync_rise;
  logic             w_pause_rise;
  logic             w_dir_s;
  logic             w_inv_s;
  logic [1:0]       w_unused_rise;
  logic             w_armed;
  logic [ARM_W-1:0] r_arm_cnt;
  logic [WIDTH-1:0] r_count;
  logic             r_paused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_slow (
    .clk(clk), .rst(rst), .i_async(slow_clk_in),
    .o_level(w_slow_lvl), .o_rise(w_slow_rise)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pause (
    .clk(clk), .rst(rst), .i_async(pause_btn),
    .o_level(w_pause_lvl), .o_rise(w_pause_sync_rise)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dir (
    .clk(clk), .rst(rst), .i_async(dir),
    .o_level(w_dir_s), .o_rise(w_unused_rise[0])
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync_inv (
    .clk(clk), .rst(rst), .i_async(inv),
    .o_level(w_inv_s), .o_rise(w_unused_rise[1])
  );

  // Holding off until the prev flop has seen the first synchronized value
  // suppresses a false edge from an input that was already high at release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm_cnt <= '0;
    end else if (!w_armed) begin
      r_arm_cnt <= r_arm_cnt + ARM_W'(1);
    end
  end

  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));

`ifdef UD_COUNTER_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_level;
  logic            r_db_prev;
  logic            w_unused_pause_rise;

  assign w_unused_pause_rise = w_pause_sync_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_db_prev  <= 1'b0;
    end else begin
      r_db_prev <= r_db_level;
      if (w_pause_lvl != r_db_level) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_db_level <= w_pause_lvl;
          r_db_cnt   <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_pause_rise = r_db_level & ~r_db_prev & w_armed;
`else
  assign w_pause_rise = w_pause_sync_rise & w_armed;
`endif

  assign tick = w_slow_rise & w_armed;

  // Count decision uses r_paused before this cycle's toggle, so a press that
  // coincides with a tick counts first when running and skips it when paused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_paused <= 1'b0;
    end else begin
      r_paused <= r_paused ^ w_pause_rise;
      if (tick && !r_paused) begin
        if (w_dir_s == DIR_UP) begin
          r_count <= r_count + WIDTH'(1);
        end else begin
          r_count <= r_count - WIDTH'(1);
        end
      end
    end
  end

  assign count  = r_count;
  assign paused = r_paused;
  assign q      = w_inv_s ? ~r_count : r_count;

endmodule
